// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift-add-3 step per clock.
// Optional leading-zero blank mask enabled by defining LEADING_ZERO_BLANK_EN.
module bin_to_bcd_converter #(
  parameter int N    = 8,
  parameter int IN_W = 14,
  localparam int DIGITS = 2*N/4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IN_W-1:0]     bin_in,
  output logic                ready,
  output logic                busy,
  output logic                valid,
  output logic                ovf,
  output logic [2*N-1:0]      bcd_out,
  output logic [DIGITS-1:0]   blank
);

  localparam int BCD_W  = 2*N;
  localparam int WORK_W = BCD_W + IN_W;
  localparam int CW     = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [IN_W:0] MAX_VAL = (IN_W+1)'(10**DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state, state_next;
  logic [WORK_W-1:0]   work;
  logic [WORK_W-1:0]   work_next;
  logic [CW-1:0]       cnt;
  logic                ovf_flag;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] s, input logic over);
    return over ? {DIGITS{4'h9}} : s;
  endfunction

  // Scratch digits sit above the binary shift register; the top carry bit falls off.
  assign work_next = {add3(work[WORK_W-1:IN_W]), work[IN_W-1:0]} << 1;

  assign ready = (state == IDLE);
  assign busy  = (state == CONV) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (cnt == CW'(IN_W - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [DIGITS-1:0] zero_mask(input logic [BCD_W-1:0] s);
    logic [DIGITS-1:0] m;
    logic              all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = DIGITS-1; i > 0; i--) begin
      all_zero = all_zero && (s[4*i +: 4] == 4'd0);
      m[i]     = all_zero;
    end
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n)              blank <= '0;
    else if (state == DONE)  blank <= ovf_flag ? '0 : zero_mask(work[WORK_W-1:IN_W]);
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work     <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      bcd_out  <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work     <= {{BCD_W{1'b0}}, bin_in};
            cnt      <= '0;
            ovf_flag <= ({1'b0, bin_in} > MAX_VAL);
          end
        end
        CONV: begin
          work <= work_next;
          cnt  <= cnt + CW'(1);
        end
        DONE: begin
          bcd_out <= saturate(work[WORK_W-1:IN_W], ovf_flag);
          ovf     <= ovf_flag;
          valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench for bin_to_bcd_converter: latency, BCD values, saturation,
// ignored start, back-to-back starts and mid-conversion reset.
module tb_bin_to_bcd_converter;

  localparam int N    = 8;
  localparam int IN_W = 14;
  localparam int DIGITS = 2*N/4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [IN_W-1:0]   bin_in;
  logic              ready, busy, valid, ovf;
  logic [2*N-1:0]    bcd_out;
  logic [DIGITS-1:0] blank;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int lat;
  int p0;

  bin_to_bcd_converter #(.N(N), .IN_W(IN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .ready(ready), .busy(busy), .valid(valid), .ovf(ovf),
    .bcd_out(bcd_out), .blank(blank)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid === 1'b1) pulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DIGITS-1:0] exp_blank(input logic [DIGITS-1:0] on_val);
`ifdef LEADING_ZERO_BLANK_EN
    return on_val;
`else
    return (on_val & '0);
`endif
  endfunction

  task automatic wait_valid(output int l);
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (valid === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic convert(input string tag, input logic [IN_W-1:0] v,
                         input logic [15:0] e_bcd, input logic e_ovf,
                         input logic [DIGITS-1:0] e_blank_on);
    int l;
    start  = 1'b1;
    bin_in = v;
    step();
    start  = 1'b0;
    bin_in = IN_W'($urandom);
    wait_valid(l);
    chk({tag, "_lat"},   l,       IN_W + 1);
    chk({tag, "_bcd"},   bcd_out, e_bcd);
    chk({tag, "_ovf"},   ovf,     e_ovf);
    chk({tag, "_blank"}, blank,   exp_blank(e_blank_on));
    step();
    chk({tag, "_pulse"}, valid,   1'b0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    step();
    step();
    chk("rst_ready", ready,   1'b1);
    chk("rst_busy",  busy,    1'b0);
    chk("rst_valid", valid,   1'b0);
    chk("rst_ovf",   ovf,     1'b0);
    chk("rst_bcd",   bcd_out, 16'h0000);
    chk("rst_blank", blank,   4'b0000);
    rst_n = 1'b1;
    step();

    convert("zero",  14'd0,     16'h0000, 1'b0, 4'b1110);
    convert("v1234", 14'd1234,  16'h1234, 1'b0, 4'b0000);
    convert("v9999", 14'd9999,  16'h9999, 1'b0, 4'b0000);
    convert("v42",   14'd42,    16'h0042, 1'b0, 4'b1100);
    convert("v10000",14'd10000, 16'h9999, 1'b1, 4'b0000);
    convert("v16383",14'd16383, 16'h9999, 1'b1, 4'b0000);
    convert("v42b",  14'd42,    16'h0042, 1'b0, 4'b1100);

    // Start re-asserted mid-conversion must be ignored.
    p0     = pulses;
    start  = 1'b1;
    bin_in = 14'd555;
    step();
    start  = 1'b0;
    step();
    step();
    chk("ign_busy", busy,  1'b1);
    chk("ign_ready", ready, 1'b0);
    start  = 1'b1;
    bin_in = 14'd7;
    repeat (5) step();
    start  = 1'b0;
    wait_valid(lat);
    chk("ign_lat",   lat + 7, IN_W + 1);
    chk("ign_bcd",   bcd_out, 16'h0555);
    chk("ign_blank", blank,   exp_blank(4'b1000));
    repeat (IN_W + 4) step();
    chk("ign_pulses", pulses - p0, 1);
    chk("ign_idle",   ready,       1'b1);

    // Continuous start: back-to-back conversions every IN_W+2 cycles.
    start  = 1'b1;
    bin_in = 14'd12;
    step();
    bin_in = 14'd3000;
    wait_valid(lat);
    chk("b2b_lat0", lat,     IN_W + 1);
    chk("b2b_bcd0", bcd_out, 16'h0012);
    bin_in = 14'd34;
    wait_valid(lat);
    start  = 1'b0;
    chk("b2b_lat1",  lat,     IN_W + 2);
    chk("b2b_bcd1",  bcd_out, 16'h0034);
    chk("b2b_blank", blank,   exp_blank(4'b1100));
    repeat (IN_W + 4) step();
    chk("b2b_idle",  ready,   1'b1);

    // Reset in the middle of a conversion.
    p0     = pulses;
    start  = 1'b1;
    bin_in = 14'd4321;
    step();
    start  = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_ready", ready,   1'b1);
    chk("mrst_busy",  busy,    1'b0);
    chk("mrst_bcd",   bcd_out, 16'h0000);
    chk("mrst_valid", valid,   1'b0);
    chk("mrst_ovf",   ovf,     1'b0);
    repeat (IN_W + 4) step();
    chk("mrst_pulses", pulses - p0, 0);
    convert("v4321", 14'd4321, 16'h4321, 1'b0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
